alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of a shared external ALU
//
// Purpose:
//    Accepts one ALU operation at a time from two requesters, latches the
//    winner's opcode and operands, drives them to a shared combinational ALU,
//    registers the ALU result and zero flag, and returns them to the winner.
//    Accept at cycle N gives a response at N+2. The minimum issue interval
//    is 3 cycles.
//
// Configuration:
//    ALU_ARB_RR_EN - when defined, a tie (ReqValid=11) is broken round-robin.
//                    When undefined, requester 0 always wins a tie and no
//                    pointer register exists.
//
// Ports:
//    Clk        in   1  rising-edge clock
//    Reset      in   1  synchronous active-high reset
//    ReqValid   in   2  per-requester request
//    ReqReady   out  2  one-hot accept strobe
//    Op0/A0/B0  in   4/8/8  requester 0 opcode and operands
//    Op1/A1/B1  in   4/8/8  requester 1 opcode and operands
//    RspValid   out  2  one-hot response valid to the granted requester
//    RspReady   in   2  per-requester response accept
//    RspResult  out  8  registered ALU result
//    RspZero    out  1  registered ALU zero flag
//    ALUOp      out  4  latched opcode to the shared ALU
//    AluA/AluB  out  8  latched operands to the shared ALU
//    AluResult  in   8  combinational ALU result
//    AluZero    in   1  combinational ALU zero flag

module alu_arbiter (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [1:0] ReqValid,
   output logic [1:0] ReqReady,
   input  logic [3:0] Op0,
   input  logic [7:0] A0,
   input  logic [7:0] B0,
   input  logic [3:0] Op1,
   input  logic [7:0] A1,
   input  logic [7:0] B1,
   output logic [1:0] RspValid,
   input  logic [1:0] RspReady,
   output logic [7:0] RspResult,
   output logic       RspZero,
   output logic [3:0] ALUOp,
   output logic [7:0] AluA,
   output logic [7:0] AluB,
   input  logic [7:0] AluResult,
   input  logic       AluZero
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0] state;
   logic       grant_q;     // index of the requester that owns the in-flight op
   logic       sel;         // index that would be granted this cycle
   logic       accept;
   logic       rsp_take;
   logic [3:0] op_q;
   logic [7:0] a_q;
   logic [7:0] b_q;
   logic [7:0] result_q;
   logic       zero_q;

`ifdef ALU_ARB_RR_EN
   // Index granted most recently; resets to 1 so requester 0 wins first.
   logic       last_q;

   always_comb begin
      sel = ~ReqValid[0];
      if (ReqValid == 2'b11) begin
         sel = ~last_q;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         last_q <= 1'b1;
      end else if (accept) begin
         last_q <= sel;
      end
   end
`else
   // Fixed priority: requester 0 wins whenever it asks.
   always_comb begin
      sel = ~ReqValid[0];
   end
`endif

   // Reset gates the accept strobe so nothing is taken while it is held.
   assign accept   = (state == S_IDLE) && (ReqValid != 2'b00) && !Reset;
   assign ReqReady = accept ? (sel ? 2'b10 : 2'b01) : 2'b00;

   // Only the granted requester's RspReady can complete the response.
   assign rsp_take = (state == S_RESP) && RspReady[grant_q];
   assign RspValid = (state == S_RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;

   assign ALUOp     = op_q;
   assign AluA      = a_q;
   assign AluB      = b_q;
   assign RspResult = result_q;
   assign RspZero   = zero_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= S_IDLE;
         grant_q  <= 1'b0;
         op_q     <= 4'd0;
         a_q      <= 8'd0;
         b_q      <= 8'd0;
         result_q <= 8'd0;
         zero_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  grant_q <= sel;
                  op_q    <= sel ? Op1 : Op0;
                  a_q     <= sel ? A1  : A0;
                  b_q     <= sel ? B1  : B0;
                  state   <= S_EXEC;
               end
            end
            S_EXEC: begin
               // The ALU has seen the latched operands for a full cycle.
               result_q <= AluResult;
               zero_q   <= AluZero;
               state    <= S_RESP;
            end
            S_RESP: begin
               if (rsp_take) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
